// File: rtl/arm_pkg.sv
// Shared types and default constants for the maze-arm pose sequencer and its PWM neighbours.
package arm_pkg;

    localparam int unsigned DEF_ANGLE_W    = 8;
    localparam int unsigned DEF_STATE_W    = 6;
    localparam int unsigned DEF_PARK_ANGLE = 90;

    typedef logic [DEF_ANGLE_W-1:0] angle_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RDY,
        S_SETTLE,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/rdy_sync_edge.sv
// Two-flop synchroniser for an asynchronous strobe plus rising-edge detect on the synchronised level.
module rdy_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    // sync_q[1] is the synchronised level, sync_q[2] its previous value
    assign rise_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/arm_pose_sequencer.sv
// Pose-table servo sequencer: issues each joint target in turn, waits for servo ready + settle, then publishes the state.
// Optional build macro SKIP_UNCHANGED_EN: joints whose target already matches the current angle are not re-issued.
module arm_pose_sequencer
    import arm_pkg::*;
#(
    parameter int unsigned N_JOINTS   = 4,
    parameter int unsigned ANGLE_W    = DEF_ANGLE_W,
    parameter int unsigned STATE_W    = DEF_STATE_W,
    parameter int unsigned N_STATES   = 36,
    parameter int unsigned PARK_ANGLE = DEF_PARK_ANGLE,
    parameter int unsigned SETTLE_CYC = 1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [STATE_W-1:0]          req_state,
    input  logic                        tbl_we,
    input  logic [STATE_W-1:0]          tbl_state,
    input  logic [$clog2(N_JOINTS)-1:0] tbl_joint,
    input  logic [ANGLE_W-1:0]          tbl_angle,
    input  logic                        rdy,
    output logic [N_JOINTS*ANGLE_W-1:0] angle,
    output logic                        t_restart,
    output logic                        move_complete,
    output logic [STATE_W-1:0]          maze_state,
    output logic                        req_err
);

    localparam int unsigned JOINT_W     = $clog2(N_JOINTS);
    localparam int unsigned CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned SETTLE_LOAD = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
    localparam logic [ANGLE_W-1:0] PARK   = ANGLE_W'(PARK_ANGLE);
    localparam logic [JOINT_W-1:0] LAST_J = JOINT_W'(N_JOINTS - 1);

    seq_state_t         state_q, state_d;
    logic [STATE_W-1:0] lat_q;
    logic [JOINT_W-1:0] j_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ANGLE_W-1:0] tbl_q [N_STATES][N_JOINTS];
    logic [ANGLE_W-1:0] ang_q [N_JOINTS];

    logic               rdy_rise_c;
    logic               accept_c, err_c, issue_c, next_j_c;
    logic               cnt_load_c, cnt_dec_c, done_c, tbl_wr_c, last_c;
    logic [ANGLE_W-1:0] tgt_c;

    rdy_sync_edge u_rdy_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (rdy),
        .rise_c (rdy_rise_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        err_c      = 1'b0;
        issue_c    = 1'b0;
        next_j_c   = 1'b0;
        cnt_load_c = 1'b0;
        cnt_dec_c  = 1'b0;
        done_c     = 1'b0;
        tgt_c      = tbl_q[lat_q][j_q];
        last_c     = (j_q == LAST_J);
        tbl_wr_c   = (state_q == S_IDLE) && tbl_we &&
                     (32'(tbl_state) < N_STATES) && (32'(tbl_joint) < N_JOINTS);

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (32'(req_state) >= N_STATES) begin
                        err_c = 1'b1;
                    end else begin
                        accept_c = 1'b1;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                issue_c = 1'b1;
                state_d = S_WAIT_RDY;
`ifdef SKIP_UNCHANGED_EN
                if (tgt_c == ang_q[j_q]) begin
                    issue_c = 1'b0;
                    if (last_c) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_ISSUE;
                        next_j_c = 1'b1;
                    end
                end
`endif
            end
            S_WAIT_RDY: begin
                if (rdy_rise_c) begin
                    if (SETTLE_CYC != 0) begin
                        cnt_load_c = 1'b1;
                        state_d    = S_SETTLE;
                    end else if (last_c) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_ISSUE;
                        next_j_c = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_dec_c = 1'b1;
                end else if (last_c) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_ISSUE;
                    next_j_c = 1'b1;
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pose table; writes only land while idle, so an in-flight move never sees them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(N_STATES); s++) begin
                for (int j = 0; j < int'(N_JOINTS); j++) begin
                    tbl_q[s][j] <= PARK;
                end
            end
        end else if (tbl_wr_c) begin
            tbl_q[tbl_state][tbl_joint] <= tbl_angle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q         <= '0;
            j_q           <= '0;
            cnt_q         <= '0;
            maze_state    <= '0;
            t_restart     <= 1'b0;
            move_complete <= 1'b0;
            req_err       <= 1'b0;
            req_ready     <= 1'b1;
            for (int j = 0; j < int'(N_JOINTS); j++) begin
                ang_q[j] <= PARK;
            end
        end else begin
            t_restart     <= issue_c;
            move_complete <= done_c;
            req_err       <= err_c;
            req_ready     <= (state_d == S_IDLE);
            if (accept_c) begin
                lat_q <= req_state;
                j_q   <= '0;
            end else if (next_j_c) begin
                j_q <= j_q + JOINT_W'(1);
            end
            if (issue_c) begin
                ang_q[j_q] <= tgt_c;
            end
            if (cnt_load_c) begin
                cnt_q <= CNT_W'(SETTLE_LOAD);
            end else if (cnt_dec_c) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (done_c) begin
                maze_state <= lat_q;
            end
        end
    end

    for (genvar g = 0; g < int'(N_JOINTS); g++) begin : g_angle
        assign angle[g*ANGLE_W +: ANGLE_W] = ang_q[g];
    end

endmodule

// File: tb/tb_arm_pose_sequencer.sv
// Directed self-checking bench for arm_pose_sequencer (SETTLE_CYC=4, N_STATES=36).
// Build with +define+SKIP_UNCHANGED_EN for both files to include the unchanged-pose test.
module tb_arm_pose_sequencer;

    localparam int unsigned NJ = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned SW = 6;
    localparam int unsigned NS = 36;
    localparam int unsigned SC = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [SW-1:0]     req_state = '0;
    logic              tbl_we = 1'b0;
    logic [SW-1:0]     tbl_state = '0;
    logic [1:0]        tbl_joint = '0;
    logic [AW-1:0]     tbl_angle = '0;
    logic              rdy = 1'b0;
    logic [NJ*AW-1:0]  angle;
    logic              t_restart;
    logic              move_complete;
    logic [SW-1:0]     maze_state;
    logic              req_err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_restart = 0;
    int n_complete = 0;

    arm_pose_sequencer #(
        .N_JOINTS(NJ), .ANGLE_W(AW), .STATE_W(SW),
        .N_STATES(NS), .PARK_ANGLE(90), .SETTLE_CYC(SC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_state(req_state),
        .tbl_we(tbl_we), .tbl_state(tbl_state), .tbl_joint(tbl_joint), .tbl_angle(tbl_angle),
        .rdy(rdy), .angle(angle), .t_restart(t_restart), .move_complete(move_complete),
        .maze_state(maze_state), .req_err(req_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (t_restart === 1'b1) n_restart++;
        if (move_complete === 1'b1) n_complete++;
    end

    function automatic logic [NJ*AW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    task automatic send_req(input int st);
        @(negedge clk);
        req_valid = 1'b1;
        req_state = SW'(st);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic tbl_write(input int st, input int j, input int a);
        @(negedge clk);
        tbl_we    = 1'b1;
        tbl_state = SW'(st);
        tbl_joint = 2'(j);
        tbl_angle = AW'(a);
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic pulse_rdy();
        rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rdy = 1'b0;
    endtask

    task automatic wait_restart(output bit found);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (t_restart === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_complete(output bit found);
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (move_complete === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic serve_joints(input int n, output int served);
        bit f;
        served = 0;
        for (int k = 0; k < n; k++) begin
            wait_restart(f);
            if (!f) break;
            pulse_rdy();
            served++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (angle !== pk(90, 90, 90, 90)) begin n_bad++; $display("FAIL reset_angle: got %h want %h", angle, pk(90, 90, 90, 90)); end
        n_cmp++; if (maze_state !== 6'd0) begin n_bad++; $display("FAIL reset_maze_state: got %0d want 0", maze_state); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if ({t_restart, move_complete, req_err} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {t_restart, move_complete, req_err}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bad_req();
        int bad_st [2] = '{40, 36};
        foreach (bad_st[k]) begin
            send_req(bad_st[k]);
            n_cmp++; if (req_err !== 1'b1) begin n_bad++; $display("FAIL bad_req_err st=%0d: got %b want 1", bad_st[k], req_err); end
            n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bad_req_ready st=%0d: got %b want 1", bad_st[k], req_ready); end
            @(negedge clk);
            n_cmp++; if (req_err !== 1'b0) begin n_bad++; $display("FAIL bad_req_err_width st=%0d: got %b want 0", bad_st[k], req_err); end
        end
        repeat (4) @(negedge clk);
        n_cmp++; if (angle !== pk(90, 90, 90, 90)) begin n_bad++; $display("FAIL bad_req_angle: got %h want %h", angle, pk(90, 90, 90, 90)); end
        n_cmp++; if (maze_state !== 6'd0) begin n_bad++; $display("FAIL bad_req_maze_state: got %0d want 0", maze_state); end
        @(posedge clk);
        n_cmp++; if (n_restart !== 0) begin n_bad++; $display("FAIL bad_req_restarts: got %0d want 0", n_restart); end
    endtask

    task automatic test_move();
        int ex [4] = '{90, 90, 90, 90};
        int nv [4] = '{10, 160, 10, 160};
        int r0, c0;
        bit f;
        for (int j = 0; j < 4; j++) tbl_write(3, j, nv[j]);
        @(posedge clk);
        r0 = n_restart;
        c0 = n_complete;
        send_req(3);
        for (int j = 0; j < 4; j++) begin
            wait_restart(f);
            n_cmp++; if (!f) begin n_bad++; $display("FAIL move_issue_j%0d: got no t_restart want pulse", j); end
            ex[j] = nv[j];
            n_cmp++; if (angle !== pk(ex[0], ex[1], ex[2], ex[3])) begin n_bad++; $display("FAIL move_angle_j%0d: got %h want %h", j, angle, pk(ex[0], ex[1], ex[2], ex[3])); end
            n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL move_busy_j%0d: got req_ready %b want 0", j, req_ready); end
            pulse_rdy();
        end
        wait_complete(f);
        n_cmp++; if (!f) begin n_bad++; $display("FAIL move_complete_seen: got none want pulse"); end
        n_cmp++; if (maze_state !== 6'd3) begin n_bad++; $display("FAIL move_maze_state: got %0d want 3", maze_state); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL move_ready_after: got %b want 1", req_ready); end
        repeat (3) @(negedge clk);
        @(posedge clk);
        n_cmp++; if (n_restart - r0 !== 4) begin n_bad++; $display("FAIL move_restart_count: got %0d want 4", n_restart - r0); end
        n_cmp++; if (n_complete - c0 !== 1) begin n_bad++; $display("FAIL move_complete_count: got %0d want 1", n_complete - c0); end
    endtask

    task automatic test_ignored_rdy();
        int nv [4] = '{20, 30, 40, 50};
        int extra = 0;
        int served;
        bit f;
        for (int j = 0; j < 4; j++) tbl_write(35, j, nv[j]);
        send_req(35);
        wait_restart(f);
        n_cmp++; if (!f) begin n_bad++; $display("FAIL ign_issue_j0: got no t_restart want pulse"); end
        // rises land in WAIT_RDY (accepted), then SETTLE and ISSUE (both ignored)
        rdy = 1'b1; @(negedge clk);
        rdy = 1'b0; @(negedge clk); @(negedge clk);
        rdy = 1'b1; @(negedge clk);
        rdy = 1'b0; @(negedge clk);
        rdy = 1'b1; @(negedge clk);
        rdy = 1'b0; @(negedge clk); @(negedge clk);
        n_cmp++; if (t_restart !== 1'b1) begin n_bad++; $display("FAIL ign_issue_j1: got %b want 1", t_restart); end
        n_cmp++; if (angle !== pk(20, 30, 10, 160)) begin n_bad++; $display("FAIL ign_angle_j1: got %h want %h", angle, pk(20, 30, 10, 160)); end
        repeat (20) begin
            @(negedge clk);
            if (t_restart === 1'b1 || move_complete === 1'b1) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL ign_stalled: got %0d pulses want 0", extra); end
        n_cmp++; if (angle !== pk(20, 30, 10, 160)) begin n_bad++; $display("FAIL ign_angle_hold: got %h want %h", angle, pk(20, 30, 10, 160)); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL ign_busy: got req_ready %b want 0", req_ready); end
        pulse_rdy();
        serve_joints(2, served);
        n_cmp++; if (served !== 2) begin n_bad++; $display("FAIL ign_resume: got %0d joints want 2", served); end
        wait_complete(f);
        n_cmp++; if (!f || maze_state !== 6'd35) begin n_bad++; $display("FAIL ign_done: got seen=%b state=%0d want seen=1 state=35", f, maze_state); end
        n_cmp++; if (angle !== pk(20, 30, 40, 50)) begin n_bad++; $display("FAIL ign_final_angle: got %h want %h", angle, pk(20, 30, 40, 50)); end
    endtask

    task automatic test_busy_write();
        int served;
        bit f;
        send_req(3);
        wait_restart(f);
        n_cmp++; if (!f) begin n_bad++; $display("FAIL busy_issue_j0: got no t_restart want pulse"); end
        tbl_write(3, 3, 77);
        pulse_rdy();
        serve_joints(3, served);
        n_cmp++; if (served !== 3) begin n_bad++; $display("FAIL busy_joints: got %0d want 3", served); end
        wait_complete(f);
        n_cmp++; if (angle !== pk(10, 160, 10, 160)) begin n_bad++; $display("FAIL busy_write_dropped: got %h want %h", angle, pk(10, 160, 10, 160)); end
        // idle write and request in the same cycle: the request sees the new entry
        @(negedge clk);
        tbl_we = 1'b1; tbl_state = 6'd35; tbl_joint = 2'd3; tbl_angle = 8'd200;
        req_valid = 1'b1; req_state = 6'd35;
        @(negedge clk);
        tbl_we = 1'b0; req_valid = 1'b0;
        serve_joints(4, served);
        n_cmp++; if (served !== 4) begin n_bad++; $display("FAIL same_cycle_joints: got %0d want 4", served); end
        wait_complete(f);
        n_cmp++; if (angle !== pk(20, 30, 40, 200)) begin n_bad++; $display("FAIL same_cycle_write: got %h want %h", angle, pk(20, 30, 40, 200)); end
        n_cmp++; if (maze_state !== 6'd35) begin n_bad++; $display("FAIL same_cycle_state: got %0d want 35", maze_state); end
    endtask

    task automatic test_reset_mid();
        int c0, served;
        bit f;
        send_req(3);
        wait_restart(f);
        pulse_rdy();
        wait_restart(f);
        n_cmp++; if (angle !== pk(10, 160, 40, 200)) begin n_bad++; $display("FAIL mid_angle_j1: got %h want %h", angle, pk(10, 160, 40, 200)); end
        @(posedge clk);
        c0 = n_complete;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (angle !== pk(90, 90, 90, 90)) begin n_bad++; $display("FAIL mid_rst_angle: got %h want %h", angle, pk(90, 90, 90, 90)); end
        n_cmp++; if (maze_state !== 6'd35 && maze_state !== 6'd0) begin n_bad++; $display("FAIL mid_rst_state_x: got %0d", maze_state); end
        n_cmp++; if (maze_state !== 6'd0) begin n_bad++; $display("FAIL mid_rst_maze_state: got %0d want 0", maze_state); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 1", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        n_cmp++; if (n_complete !== c0) begin n_bad++; $display("FAIL mid_rst_no_complete: got %0d want %0d", n_complete, c0); end
        for (int j = 0; j < 4; j++) tbl_write(5, j, j + 1);
        send_req(5);
        wait_restart(f);
        n_cmp++; if (!f || angle !== pk(1, 90, 90, 90)) begin n_bad++; $display("FAIL mid_restart_j0: got seen=%b angle=%h want seen=1 angle=%h", f, angle, pk(1, 90, 90, 90)); end
        pulse_rdy();
        serve_joints(3, served);
        wait_complete(f);
        n_cmp++; if (!f || maze_state !== 6'd5) begin n_bad++; $display("FAIL mid_rerun_done: got seen=%b state=%0d want seen=1 state=5", f, maze_state); end
        // table row 3 was cleared to park by the reset
        send_req(3);
        serve_joints(4, served);
        wait_complete(f);
        n_cmp++; if (angle !== pk(90, 90, 90, 90)) begin n_bad++; $display("FAIL mid_tbl_reset: got %h want %h", angle, pk(90, 90, 90, 90)); end
        n_cmp++; if (maze_state !== 6'd3) begin n_bad++; $display("FAIL mid_tbl_reset_state: got %0d want 3", maze_state); end
    endtask

`ifdef SKIP_UNCHANGED_EN
    task automatic test_skip_unchanged();
        int r0;
        @(posedge clk);
        r0 = n_restart;
        send_req(3);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_cmp++; if (move_complete !== 1'b0) begin n_bad++; $display("FAIL skip_early_complete k=%0d: got 1 want 0", k); end
        end
        @(negedge clk);
        n_cmp++; if (move_complete !== 1'b1) begin n_bad++; $display("FAIL skip_latency: got %b want 1 at accept+5", move_complete); end
        @(posedge clk);
        n_cmp++; if (n_restart !== r0) begin n_bad++; $display("FAIL skip_restarts: got %0d want 0", n_restart - r0); end
    endtask
`endif

    initial begin
        test_reset();
        test_bad_req();
        test_move();
        test_ignored_rdy();
        test_busy_write();
        test_reset_mid();
`ifdef SKIP_UNCHANGED_EN
        test_skip_unchanged();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
